// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//
// Collects a framed byte stream (valid/ready) into two NxN operand matrices,
// A first and then B, both row-major. It then pulses `start` to the downstream
// subtractor and holds the operands stable until `done` arrives or the wait
// times out. Malformed frames, B elements larger than their A partner, and a
// stalled downstream stage raise sticky flags. Those flags clear on byte 0 of
// the following frame.
//
// Ports
//   clk, rst            clock and asynchronous active-high reset
//   in_valid/in_ready   byte handshake; in_ready is high only while loading
//   in_data, in_last    stream byte and end-of-frame marker
//   a, b                operand matrices driven to the subtractor
//   start               held high for START_CYCLES cycles per accepted frame
//   done                completion from the subtractor (used only while waiting)
//   busy                high while starting or waiting for done
//   frame_err           sticky: last frame was discarded
//   underflow           sticky: some b[i][j] > a[i][j] in the last frame
//   timeout             sticky: done was not seen within TIMEOUT_CYCLES
module matrix_operand_loader #(
  parameter int N              = 4,
  parameter int DATA_W         = 8,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_last,
  output logic [0:N-1][0:N-1][DATA_W-1:0] a,
  output logic [0:N-1][0:N-1][DATA_W-1:0] b,
  output logic                            start,
  input  logic                            done,
  output logic                            busy,
  output logic                            frame_err,
  output logic                            underflow,
  output logic                            timeout
);

  localparam int ELEMS = N * N;
  localparam int FRAME = 2 * ELEMS;
  localparam int IDX_W = $clog2(FRAME);
  localparam int RC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int SC_W  = $clog2(START_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME - 1);
  localparam logic [IDX_W-1:0] A_LAST   = IDX_W'(ELEMS - 1);
  localparam logic [IDX_W-1:0] B_BASE   = IDX_W'(ELEMS);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(START_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    st_load_a,
    st_load_b,
    st_start,
    st_wait_done
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [SC_W-1:0]   start_cnt_reg, start_cnt_next;
  logic [TO_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic              start_reg, start_next;
  logic              busy_reg, busy_next;
  logic              frame_err_reg, frame_err_next;
  logic              underflow_reg, underflow_next;
  logic              timeout_reg, timeout_next;
  // Keeps in_ready low while reset is asserted; it rises on the first edge
  // after release even though the state register already reads LOAD_A.
  logic              ready_en_reg;

  logic              accept;
  logic              is_b;
  logic              bad_last;
  logic [IDX_W-1:0]  el;
  logic [RC_W-1:0]   row;
  logic [RC_W-1:0]   col;

  assign in_ready = ready_en_reg && ((state_reg == st_load_a) || (state_reg == st_load_b));
  assign accept   = in_valid && in_ready;

  // Element position of the current byte inside its own matrix.
  assign is_b = (idx_reg >= B_BASE);
  assign el   = is_b ? (idx_reg - B_BASE) : idx_reg;
  assign row  = RC_W'(el / IDX_W'(N));
  assign col  = RC_W'(el % IDX_W'(N));

  // The end marker must coincide exactly with the last byte of the frame.
  assign bad_last = (in_last && (idx_reg != LAST_IDX)) || (!in_last && (idx_reg == LAST_IDX));

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    start_cnt_next = start_cnt_reg;
    wait_cnt_next  = wait_cnt_reg;
    frame_err_next = frame_err_reg;
    underflow_next = underflow_reg;
    timeout_next   = timeout_reg;

    case (state_reg)
      st_load_a, st_load_b: begin
        if (accept) begin
          // Clear first so that a flag raised by byte 0 itself survives.
          if (idx_reg == '0) begin
            frame_err_next = 1'b0;
            underflow_next = 1'b0;
            timeout_next   = 1'b0;
          end
          if (is_b && (in_data > a[row][col])) begin
            underflow_next = 1'b1;
          end
          if (bad_last) begin
            frame_err_next = 1'b1;
            idx_next       = '0;
            state_next     = st_load_a;
          end else if (idx_reg == LAST_IDX) begin
            idx_next       = '0;
            start_cnt_next = '0;
            state_next     = st_start;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
            if (idx_reg == A_LAST) begin
              state_next = st_load_b;
            end
          end
        end
      end

      st_start: begin
        if (start_cnt_reg == SC_LAST) begin
          wait_cnt_next = '0;
          state_next    = st_wait_done;
        end else begin
          start_cnt_next = start_cnt_reg + SC_W'(1);
        end
      end

      st_wait_done: begin
        if (done) begin
          state_next = st_load_a;
        end else if (wait_cnt_reg == TO_LAST) begin
          timeout_next = 1'b1;
          state_next   = st_load_a;
        end else begin
          wait_cnt_next = wait_cnt_reg + TO_W'(1);
        end
      end

      default: begin
        state_next = st_load_a;
        idx_next   = '0;
      end
    endcase

    // start/busy are registered copies of the upcoming state so they line up
    // with the state register rather than lagging it by a cycle.
    start_next = (state_next == st_start);
    busy_next  = (state_next == st_start) || (state_next == st_wait_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= st_load_a;
      idx_reg       <= '0;
      start_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      underflow_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      start_cnt_reg <= start_cnt_next;
      wait_cnt_reg  <= wait_cnt_next;
      start_reg     <= start_next;
      busy_reg      <= busy_next;
      frame_err_reg <= frame_err_next;
      underflow_reg <= underflow_next;
      timeout_reg   <= timeout_next;
      ready_en_reg  <= 1'b1;
    end
  end

  // Operand storage: only an accepted byte writes, so a and b stay frozen
  // from byte 31 until the next frame's byte 0 lands in a[0][0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
    end else if (accept) begin
      if (is_b) begin
        b[row][col] <= in_data;
      end else begin
        a[row][col] <= in_data;
      end
    end
  end

  assign start     = start_reg;
  assign busy      = busy_reg;
  assign frame_err = frame_err_reg;
  assign underflow = underflow_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader with a small subtractor model that
// returns done a few cycles after start and captures c = a - b at that moment.
module tb_matrix_operand_loader;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SC = 2;
  localparam int TO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, start, busy, frame_err, underflow, timeout;
  logic [0:N-1][0:N-1][DW-1:0] a, b;
  logic model_done = 1'b0;
  logic manual_done = 1'b0;
  logic done;

  int total = 0;
  int bad = 0;

  bit model_never = 1'b0;
  int dcnt = 0;
  bit start_q = 1'b0;
  int starts = 0;
  logic [7:0] c_model [4][4];
  logic [7:0] fa [4][4];
  logic [7:0] fb [4][4];

  assign done = model_done | manual_done;

  always #5 clk = ~clk;

  matrix_operand_loader #(
    .N(N), .DATA_W(DW), .START_CYCLES(SC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .a(a), .b(b), .start(start), .done(done), .busy(busy),
    .frame_err(frame_err), .underflow(underflow), .timeout(timeout)
  );

  // Subtractor model: done for one cycle, a fixed delay after start rises.
  always @(negedge clk) begin
    if (rst) begin
      model_done = 1'b0;
      dcnt = 0;
      start_q = 1'b0;
    end else begin
      model_done = 1'b0;
      if (start && !start_q) begin
        starts++;
        if (!model_never) dcnt = SC + 3;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          model_done = 1'b1;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              c_model[i][j] = a[i][j] - b[i][j];
        end
      end
      start_q = start;
    end
  end

  function automatic logic [0:N-1][0:N-1][DW-1:0] exp_mat(input bit sel_b);
    logic [0:N-1][0:N-1][DW-1:0] m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        m[i][j] = sel_b ? fb[i][j] : fa[i][j];
    return m;
  endfunction

  task automatic set_nominal();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        fa[i][j] = 8'(16 * i + 4 * j + 100);
        fb[i][j] = 8'(i + j);
      end
  endtask

  task automatic set_random();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        fa[i][j] = 8'($urandom_range(255, 0));
        fb[i][j] = 8'($urandom_range(int'(fa[i][j]), 0));
      end
  endtask

  function automatic logic [7:0] frame_byte(input int k);
    if (k < 16) return fa[k / 4][k % 4];
    return fb[(k - 16) / 4][(k - 16) % 4];
  endfunction

  // Presents one byte; returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int w;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    w = 0;
    while (in_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) begin
      total++;
      bad++;
      $display("FAIL handshake_wait: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int k = 0; k < 32; k++)
      send_byte(frame_byte(k), (k == 31), gaps ? int'($urandom_range(2, 0)) : 0);
  endtask

  // Returns #1 after the edge at which done was sampled high.
  task automatic wait_done_seen(input string name);
    int w;
    w = 0;
    @(posedge clk);
    while (done !== 1'b1 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    total++;
    if (w >= 200) begin
      bad++;
      $display("FAIL %s_done_wait: done not seen within 200 cycles", name);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    total++;
    if ({start, busy, frame_err, underflow, timeout} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: start/busy/ferr/uf/to=%b required 00000",
                      {start, busy, frame_err, underflow, timeout});
    end
    total++;
    if (a !== '0 || b !== '0) begin bad++; $display("FAIL reset_mats: a=%h b=%h required 0", a, b); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_nominal();
    int s0;
    set_nominal();
    s0 = starts;
    send_frame(1'b0);
    total++;
    if ({start, busy, in_ready} !== 3'b110) begin
      bad++; $display("FAIL nom_start1: start/busy/ready=%b required 110", {start, busy, in_ready});
    end
    total++;
    if (a !== exp_mat(1'b0)) begin bad++; $display("FAIL nom_a: got %h required %h", a, exp_mat(1'b0)); end
    total++;
    if (b !== exp_mat(1'b1)) begin bad++; $display("FAIL nom_b: got %h required %h", b, exp_mat(1'b1)); end
    @(posedge clk);
    #1;
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL nom_start2: got %b required 1", start); end
    @(posedge clk);
    #1;
    total++;
    if ({start, busy} !== 2'b01) begin bad++; $display("FAIL nom_start_end: start/busy=%b required 01", {start, busy}); end
    total++;
    if (starts - s0 !== 1) begin bad++; $display("FAIL nom_start_count: got %0d required 1", starts - s0); end
    wait_done_seen("nom");
    total++;
    if ({busy, in_ready} !== 2'b01) begin bad++; $display("FAIL nom_release: busy/ready=%b required 01", {busy, in_ready}); end
    total++;
    if ({frame_err, underflow, timeout} !== 3'b000) begin
      bad++; $display("FAIL nom_flags: ferr/uf/to=%b required 000", {frame_err, underflow, timeout});
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (c_model[i][j] !== 8'(fa[i][j] - fb[i][j])) begin
          bad++; $display("FAIL nom_c[%0d][%0d]: got %h required %h", i, j, c_model[i][j], 8'(fa[i][j] - fb[i][j]));
        end
      end
  endtask

  task automatic test_gaps();
    int w;
    set_random();
    send_frame(1'b1);
    // Keep offering a junk byte while busy; none may be taken.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    in_last  = 1'b0;
    w = 0;
    @(negedge clk);
    while (busy === 1'b1 && w < 200) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL gap_ready_busy: in_ready=%b required 0", in_ready); end
      @(negedge clk);
      w++;
    end
    in_valid = 1'b0;
    total++;
    if (w >= 200) begin bad++; $display("FAIL gap_busy_wait: busy still %b after 200 cycles", busy); end
    @(posedge clk);
    #1;
    total++;
    if (a !== exp_mat(1'b0)) begin bad++; $display("FAIL gap_a: got %h required %h", a, exp_mat(1'b0)); end
    total++;
    if (b !== exp_mat(1'b1)) begin bad++; $display("FAIL gap_b: got %h required %h", b, exp_mat(1'b1)); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (c_model[i][j] !== 8'(fa[i][j] - fb[i][j])) begin
          bad++; $display("FAIL gap_c[%0d][%0d]: got %h required %h", i, j, c_model[i][j], 8'(fa[i][j] - fb[i][j]));
        end
      end
  endtask

  task automatic test_underflow();
    int s0;
    set_nominal();
    fa[2][3] = 8'd5;
    fb[2][3] = 8'd9;
    s0 = starts;
    for (int k = 0; k < 27; k++) send_byte(frame_byte(k), 1'b0, 0);
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL uf_before27: got %b required 0", underflow); end
    send_byte(frame_byte(27), 1'b0, 0);
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL uf_after27: got %b required 1", underflow); end
    for (int k = 28; k < 32; k++) send_byte(frame_byte(k), (k == 31), 0);
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL uf_start: got %b required 1", start); end
    wait_done_seen("uf");
    total++;
    if (starts - s0 !== 1) begin bad++; $display("FAIL uf_start_count: got %0d required 1", starts - s0); end
    total++;
    if (c_model[2][3] !== 8'hFC) begin bad++; $display("FAIL uf_c23: got %h required fc", c_model[2][3]); end
    total++;
    if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky: got %b required 1", underflow); end
    set_nominal();
    send_byte(frame_byte(0), 1'b0, 0);
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clear_byte0: got %b required 0", underflow); end
    for (int k = 1; k < 32; k++) send_byte(frame_byte(k), (k == 31), 0);
    wait_done_seen("uf2");
    total++;
    if (underflow !== 1'b0) begin bad++; $display("FAIL uf_clean_frame: got %b required 0", underflow); end
  endtask

  task automatic test_frame_err();
    int s0;
    s0 = starts;
    for (int k = 0; k <= 10; k++) send_byte(8'(k + 1), (k == 10), 0);
    total++;
    if ({frame_err, in_ready, busy} !== 3'b110) begin
      bad++; $display("FAIL ferr_early_last: ferr/ready/busy=%b required 110", {frame_err, in_ready, busy});
    end
    send_byte(8'h5A, 1'b0, 0);
    total++;
    if (a[0][0] !== 8'h5A) begin bad++; $display("FAIL ferr_restart_a00: got %h required 5a", a[0][0]); end
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear_byte0: got %b required 0", frame_err); end
    for (int k = 1; k < 32; k++) send_byte(8'(k), 1'b0, 0);
    total++;
    if ({frame_err, in_ready, start} !== 3'b110) begin
      bad++; $display("FAIL ferr_no_last: ferr/ready/start=%b required 110", {frame_err, in_ready, start});
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (starts - s0 !== 0) begin bad++; $display("FAIL ferr_no_start: starts=%0d required 0", starts - s0); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b required 0", busy); end
  endtask

  task automatic test_timeout();
    set_nominal();
    model_never = 1'b1;
    send_frame(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({start, busy} !== 2'b01) begin bad++; $display("FAIL to_wait_entry: start/busy=%b required 01", {start, busy}); end
    repeat (TO - 1) @(posedge clk);
    #1;
    total++;
    if ({timeout, busy} !== 2'b01) begin bad++; $display("FAIL to_early: timeout/busy=%b required 01", {timeout, busy}); end
    @(posedge clk);
    #1;
    total++;
    if ({timeout, busy, in_ready} !== 3'b101) begin
      bad++; $display("FAIL to_fire: timeout/busy/ready=%b required 101", {timeout, busy, in_ready});
    end
    @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({timeout, busy, in_ready, start} !== 4'b1010) begin
      bad++; $display("FAIL to_late_done: timeout/busy/ready/start=%b required 1010", {timeout, busy, in_ready, start});
    end
    model_never = 1'b0;
    send_byte(frame_byte(0), 1'b0, 0);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL to_clear_byte0: got %b required 0", timeout); end
  endtask

  // Runs straight after test_timeout, which left one byte of a frame accepted.
  task automatic test_reset_mid();
    for (int k = 1; k < 20; k++) send_byte(frame_byte(k), 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = frame_byte(20);
    #2;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    total++;
    if ({in_ready, start, busy, frame_err, underflow, timeout} !== 6'b0) begin
      bad++; $display("FAIL rst_mid_frame_ctrl: %b required 000000", {in_ready, start, busy, frame_err, underflow, timeout});
    end
    total++;
    if (a !== '0 || b !== '0) begin bad++; $display("FAIL rst_mid_frame_mats: a=%h b=%h required 0", a, b); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_release: got %b required 1", in_ready); end

    set_random();
    send_frame(1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rst_wait_pre: busy=%b required 1", busy); end
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, start, busy, frame_err, underflow, timeout} !== 6'b0) begin
      bad++; $display("FAIL rst_wait_ctrl: %b required 000000", {in_ready, start, busy, frame_err, underflow, timeout});
    end
    total++;
    if (a !== '0 || b !== '0) begin bad++; $display("FAIL rst_wait_mats: a=%h b=%h required 0", a, b); end
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_wait_release: got %b required 1", in_ready); end
    set_random();
    send_frame(1'b0);
    wait_done_seen("rst_fresh");
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        total++;
        if (c_model[i][j] !== 8'(fa[i][j] - fb[i][j])) begin
          bad++; $display("FAIL rst_fresh_c[%0d][%0d]: got %h required %h", i, j, c_model[i][j], 8'(fa[i][j] - fb[i][j]));
        end
      end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 1000; f++) begin
      set_random();
      send_frame(1'b0);
      wait_done_seen("rnd");
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          total++;
          if (c_model[i][j] !== 8'(fa[i][j] - fb[i][j])) begin
            bad++; $display("FAIL rnd_c f%0d [%0d][%0d]: got %h required %h", f, i, j, c_model[i][j], 8'(fa[i][j] - fb[i][j]));
          end
        end
      total++;
      if ({frame_err, underflow, timeout} !== 3'b000) begin
        bad++; $display("FAIL rnd_flags f%0d: ferr/uf/to=%b required 000", f, {frame_err, underflow, timeout});
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gaps();
    test_underflow();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for `matrix_subtraction`. Accepts a framed byte stream over a valid/ready handshake and assembles two 4x4 8-bit operand matrices (A then B, row-major). It then drives the `a`/`b` matrix ports and the `start` pulse of the subtraction stage, and waits for its `done` before accepting the next frame. It also flags malformed frames, operands that would give a negative result, and a stalled downstream stage.

## Interface
- `N`, 4: matrix dimension. Frame length is 2·N·N bytes.
- `DATA_W`, 8: element width.
- `START_CYCLES`, 2: number of cycles `start` is held high.
- `TIMEOUT_CYCLES`, 1024: maximum cycles to wait for `done`.

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  stream byte valid.
- `in_ready`  out  1  loader can accept a byte.
- `in_data`  in  DATA_W  stream byte.
- `in_last`  in  1  marks the final byte of a frame.
- `a`  out  [0:N-1][0:N-1] x DATA_W  operand A to the subtractor.
- `b`  out  [0:N-1][0:N-1] x DATA_W  operand B to the subtractor.
- `start`  out  1  start to the subtractor.
- `done`  in  1  completion from the subtractor.
- `busy`  out  1  high in START and WAIT_DONE.
- `frame_err`  out  1  sticky: frame discarded.
- `underflow`  out  1  sticky: some b[i][j] > a[i][j] in the last frame.
- `timeout`  out  1  sticky: `done` was not seen within TIMEOUT_CYCLES.

## Operation
- A byte transfers when `in_valid && in_ready`. `in_ready` = 1 only in LOAD_A and LOAD_B.
- A 5-bit index `idx` counts accepted bytes, 0..31.
  - Bytes 0..15 are written to `a[idx/4][idx%4]`.
  - Bytes 16..31 are written to `b[(idx-16)/4][(idx-16)%4]`.
- States:
  - LOAD_A: advance to LOAD_B after byte 15.
  - LOAD_B: after byte 31 with `in_last`=1, go to START.
  - START: `start`=1 for START_CYCLES cycles, then go to WAIT_DONE.
  - WAIT_DONE: on `done`=1 go to LOAD_A with `idx`=0. On timeout go to LOAD_A.
- Frame errors (discard the frame, go to LOAD_A, set `idx`=0, set `frame_err`):
  - `in_last`=1 accepted with `idx` ≠ 31.
  - Byte 31 accepted with `in_last`=0.
  - A discarded frame never asserts `start`.
- Underflow:
  - Checked on each accepted B byte: if `in_data` > `a[row][col]`, set `underflow`.
  - The frame still proceeds. The subtractor result for that element is modular.
- Sticky flag clearing:
  - `frame_err`, `underflow` and `timeout` clear when byte 0 of the next frame is accepted.
  - A flag set by that same byte takes precedence over the clear.
- Holding `a`/`b`:
  - Registers change only on accepted bytes.
  - Contents are stable from byte 31 through the end of WAIT_DONE.
  - Element [0][0] of A is overwritten when the next frame's byte 0 is accepted.
- `done` is ignored outside WAIT_DONE.
- Timeout counter:
  - Cleared on entering WAIT_DONE and counts each WAIT_DONE cycle.
  - When it reaches TIMEOUT_CYCLES-1 with `done`=0, set `timeout` and go to LOAD_A.
- Reset, including mid-frame or mid-WAIT:
  - State = LOAD_A, `idx`=0.
  - `a`, `b` all zero.
  - `start`, `busy` and all flags = 0.
  - `in_ready`=1 from the first clock edge after `rst` deasserts.

## Timing
- All outputs are registered. `in_ready` is decoded from the state register.
- Byte 31 accepted at edge T:
  - `in_ready`=0, `busy`=1 and `start`=1 in cycles T+1..T+START_CYCLES.
  - WAIT_DONE begins at T+START_CYCLES+1.
- `done` sampled high at edge D: `busy`=0 and `in_ready`=1 from D+1. The next byte can be accepted at edge D+1.
- Throughput: 32 byte-cycles + START_CYCLES + subtractor latency + 1 cycle per frame.
- `in_valid` may drop at any point. Gaps do not affect `idx`.
- `in_data` and `in_last` are sampled only on handshake.

## Test plan
- **Nominal frame:** A[i][j]=16i+4j+100, B[i][j]=i+j, contiguous valid, `in_last` on byte 31.
  - `start` high exactly 2 cycles starting the cycle after byte 31.
  - `a`/`b` match.
  - The model returns `done` 3 cycles later; `in_ready` returns the cycle after `done`.
  - No flags set.
- **Backpressure and gaps:** random `in_valid` gaps, `in_valid` held high during START/WAIT_DONE.
  - No byte is accepted while `busy`=1.
  - Matrices are correct.
- **Underflow:** frame with A[2][3]=5, B[2][3]=9.
  - `underflow`=1 after byte 27 and `start` still pulses.
  - Next frame with B ≤ A clears `underflow` on its byte 0.
- **Frame errors:**
  - `in_last` on byte 10: `frame_err`=1, no `start`, next byte lands in a[0][0].
  - 32 bytes without `in_last`: `frame_err`=1, no `start`.
- **Timeout:** model never asserts `done`.
  - `timeout`=1 exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry.
  - `in_ready`=1 the next cycle.
  - Late `done` is ignored.
- **Reset mid-operation:** assert `rst` during byte 20 and again during WAIT_DONE.
  - All outputs zero immediately (asynchronous).
  - After release, a fresh 32-byte frame completes normally; 1000 random frames with B ≤ A give 16000/16000 matching c.
